// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Brief    : MEM-stage data access responder. Accepts one read or write at a
//            time over a valid/ready handshake, models a data RAM with a fixed
//            programmable latency and returns a single-cycle response pulse.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                req_write_i,
    input  logic [31:0]         req_addr_i,
    input  logic [DATA_W-1:0]   req_wdata_i,
    input  logic [DATA_W/8-1:0] req_wstrb_i,
    output logic                resp_valid_o,
    output logic [DATA_W-1:0]   resp_rdata_o,
    output logic                resp_err_o
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_IDX_W  = $clog2(DEPTH_WORDS);
    localparam int c_STRB_W = DATA_W / 8;
    // Down-counter width; kept at least one bit so LATENCY == 1 still elaborates.
    localparam int c_CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    // BUSY spends LATENCY-1 cycles (count LATENCY-2 down to 0) before RESP.
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD =
        c_CNT_W'((LATENCY >= 2) ? (LATENCY - 2) : 0);
    // First byte address past the end of the RAM.
    localparam logic [32:0] c_ADDR_LIMIT = 33'(DEPTH_WORDS) * 33'd4;

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_next;
    logic                 w_enter_resp;

    // Request captured at accept time
    logic                 r_write;
    logic [31:0]          r_addr;
    logic [DATA_W-1:0]    r_wdata;
    logic [c_STRB_W-1:0]  r_wstrb;

    // Request as seen on the edge that enters RESP. With LATENCY == 1 that
    // edge is the accept edge itself, so the live inputs are used directly.
    logic                 w_cur_write;
    logic [31:0]          w_cur_addr;
    logic [DATA_W-1:0]    w_cur_wdata;
    logic [c_STRB_W-1:0]  w_cur_wstrb;

    logic                 w_accept;
    logic                 w_err;
    logic [c_IDX_W-1:0]   w_idx;
    logic                 w_mem_we;

    // Response registers, loaded on entry to RESP
    logic [DATA_W-1:0]    r_rdata;
    logic                 r_err;

    // Data RAM, contents are not reset
    logic [DATA_W-1:0]    r_mem [DEPTH_WORDS];

    assign w_accept = req_valid_i && req_ready_o;

    // Select the live request in IDLE, the latched one otherwise.
    always_comb begin
        w_cur_write = r_write;
        w_cur_addr  = r_addr;
        w_cur_wdata = r_wdata;
        w_cur_wstrb = r_wstrb;
        if (r_state == ST_IDLE) begin
            w_cur_write = req_write_i;
            w_cur_addr  = req_addr_i;
            w_cur_wdata = req_wdata_i;
            w_cur_wstrb = req_wstrb_i;
        end
    end

    // Misaligned or out-of-range addresses are errors; index is the word address.
    always_comb begin
        w_err = (w_cur_addr[1:0] != 2'b00) || ({1'b0, w_cur_addr} >= c_ADDR_LIMIT);
        w_idx = w_cur_addr[c_IDX_W+1:2];
    end

    // Write commits on the RESP entry edge; a reset on that edge discards it.
    assign w_mem_we = w_enter_resp && w_cur_write && !w_err && rst_i;

    // Capture the request on the accept edge; inputs are don't-care afterwards.
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_write <= req_write_i;
            r_addr  <= req_addr_i;
            r_wdata <= req_wdata_i;
            r_wstrb <= req_wstrb_i;
        end
    end

    // FSM state and latency counter register.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state, counter and ready decode.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_enter_resp = 1'b0;
        req_ready_o  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    if (LATENCY == 1) begin
                        w_state_next = ST_RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        w_state_next = ST_BUSY;
                        w_cnt_next   = c_CNT_LOAD;
                    end
                end
            end
            ST_BUSY: begin
                if (r_cnt == '0) begin
                    w_state_next = ST_RESP;
                    w_enter_resp = 1'b1;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            ST_RESP: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Byte-enabled RAM write.
    always_ff @(posedge clk_i) begin
        if (w_mem_we) begin
            for (int n = 0; n < c_STRB_W; n++) begin
                if (w_cur_wstrb[n]) begin
                    r_mem[w_idx][8*n +: 8] <= w_cur_wdata[8*n +: 8];
                end
            end
        end
    end

    // Response data/error captured on entry to RESP; writes and errors return 0.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_enter_resp) begin
            r_err   <= w_err;
            r_rdata <= (!w_cur_write && !w_err) ? r_mem[w_idx] : '0;
        end
    end

    // Response outputs are zero outside the single RESP cycle.
    always_comb begin
        resp_valid_o = (r_state == ST_RESP);
        resp_rdata_o = resp_valid_o ? r_rdata : '0;
        resp_err_o   = resp_valid_o ? r_err   : 1'b0;
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_responder
// Brief    : Directed self-checking bench for data_mem_responder
//            (LATENCY = 2, DEPTH_WORDS = 1024).
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int n_checks = 0;
    int n_pass   = 0;

    data_mem_responder #(
        .DATA_W      (32),
        .DEPTH_WORDS (1024),
        .LATENCY     (2)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_write_i  (req_write),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .req_wstrb_i  (req_wstrb),
        .resp_valid_o (resp_valid),
        .resp_rdata_o (resp_rdata),
        .resp_err_o   (resp_err)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request and wait (bounded) for its response pulse.
    // lat counts cycles from the accept edge to the cycle holding resp_valid.
    task automatic do_req(input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] ws,
                          output logic [31:0] rd, output logic err,
                          output int lat, output bit ok);
        int cyc;
        ok  = 1'b0;
        lat = 0;
        rd  = '0;
        err = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        req_wstrb = ws;
        cyc = 0;
        while (req_ready !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        if (req_ready !== 1'b1) begin
            req_valid = 1'b0;
            return;
        end
        do begin
            @(negedge clk);
            if (lat == 0) begin
                req_valid = 1'b0;
                req_write = 1'($urandom);
                req_addr  = $urandom;
                req_wdata = $urandom;
                req_wstrb = 4'($urandom);
            end
            lat++;
        end while (resp_valid !== 1'b1 && lat < 20);
        if (resp_valid === 1'b1) begin
            ok  = 1'b1;
            rd  = resp_rdata;
            err = resp_err;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", req_ready);
        else n_pass++;
        n_checks++;
        if (resp_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", resp_valid);
        else n_pass++;
        n_checks++;
        if (resp_err !== 1'b0) $display("FAIL reset_err: got %b expected 0", resp_err);
        else n_pass++;
        n_checks++;
        if (resp_rdata !== 32'h0) $display("FAIL reset_rdata: got %h expected 00000000", resp_rdata);
        else n_pass++;
    endtask

    task automatic test_write_read();
        logic [31:0] rd;
        logic        err;
        int          lat;
        bit          ok;
        do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, err, lat, ok);
        n_checks++;
        if ({ok, lat} !== {1'b1, 32'd2}) $display("FAIL wr_latency: got ok=%0d lat=%0d expected ok=1 lat=2", ok, lat);
        else n_pass++;
        n_checks++;
        if ({err, rd} !== {1'b0, 32'h0}) $display("FAIL wr_resp: got err=%b rdata=%h expected err=0 rdata=00000000", err, rd);
        else n_pass++;
        do_req(1'b0, 32'h10, 32'h0, 4'h0, rd, err, lat, ok);
        n_checks++;
        if ({ok, lat} !== {1'b1, 32'd2}) $display("FAIL rd_latency: got ok=%0d lat=%0d expected ok=1 lat=2", ok, lat);
        else n_pass++;
        n_checks++;
        if ({err, rd} !== {1'b0, 32'hDEADBEEF}) $display("FAIL rd_data: got err=%b rdata=%h expected err=0 rdata=deadbeef", err, rd);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (resp_valid !== 1'b0) $display("FAIL resp_pulse: got valid=%b one cycle after response expected 0", resp_valid);
        else n_pass++;
    endtask

    task automatic test_partial_write();
        logic [31:0] rd;
        logic        err;
        int          lat;
        bit          ok;
        do_req(1'b1, 32'h10, 32'h000000AA, 4'h1, rd, err, lat, ok);
        do_req(1'b0, 32'h10, 32'h0, 4'h0, rd, err, lat, ok);
        n_checks++;
        if ({ok, err, rd} !== {1'b1, 1'b0, 32'hDEADBEAA}) $display("FAIL strb_byte0: got ok=%0d err=%b rdata=%h expected deadbeaa", ok, err, rd);
        else n_pass++;
        do_req(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, rd, err, lat, ok);
        n_checks++;
        if ({ok, err} !== {1'b1, 1'b0}) $display("FAIL strb_zero_resp: got ok=%0d err=%b expected ok=1 err=0", ok, err);
        else n_pass++;
        do_req(1'b0, 32'h10, 32'h0, 4'h0, rd, err, lat, ok);
        n_checks++;
        if ({ok, rd} !== {1'b1, 32'hDEADBEAA}) $display("FAIL strb_zero_data: got ok=%0d rdata=%h expected deadbeaa", ok, rd);
        else n_pass++;
        do_req(1'b1, 32'h10, 32'h11223344, 4'hA, rd, err, lat, ok);
        do_req(1'b0, 32'h10, 32'h0, 4'h0, rd, err, lat, ok);
        n_checks++;
        if ({ok, rd} !== {1'b1, 32'h11AD33AA}) $display("FAIL strb_bytes13: got ok=%0d rdata=%h expected 11ad33aa", ok, rd);
        else n_pass++;
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        logic        err;
        int          lat;
        bit          ok;
        do_req(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, rd, err, lat, ok);
        do_req(1'b1, 32'hFFC, 32'h0BADC0DE, 4'hF, rd, err, lat, ok);
        do_req(1'b0, 32'hFFC, 32'h0, 4'h0, rd, err, lat, ok);
        n_checks++;
        if ({ok, err, rd} !== {1'b1, 1'b0, 32'h0BADC0DE}) $display("FAIL last_word: got ok=%0d err=%b rdata=%h expected err=0 0badc0de", ok, err, rd);
        else n_pass++;
        do_req(1'b0, 32'h12, 32'h0, 4'h0, rd, err, lat, ok);
        n_checks++;
        if ({ok, lat, err, rd} !== {1'b1, 32'd2, 1'b1, 32'h0}) $display("FAIL rd_misaligned: got ok=%0d lat=%0d err=%b rdata=%h expected err=1 rdata=0", ok, lat, err, rd);
        else n_pass++;
        do_req(1'b0, 32'h1000, 32'h0, 4'h0, rd, err, lat, ok);
        n_checks++;
        if ({ok, err, rd} !== {1'b1, 1'b1, 32'h0}) $display("FAIL rd_range: got ok=%0d err=%b rdata=%h expected err=1 rdata=0", ok, err, rd);
        else n_pass++;
        do_req(1'b1, 32'h1000, 32'h55555555, 4'hF, rd, err, lat, ok);
        n_checks++;
        if ({ok, err, rd} !== {1'b1, 1'b1, 32'h0}) $display("FAIL wr_range: got ok=%0d err=%b rdata=%h expected err=1 rdata=0", ok, err, rd);
        else n_pass++;
        do_req(1'b1, 32'h2, 32'h77777777, 4'hF, rd, err, lat, ok);
        n_checks++;
        if ({ok, err} !== {1'b1, 1'b1}) $display("FAIL wr_misaligned: got ok=%0d err=%b expected err=1", ok, err);
        else n_pass++;
        do_req(1'b0, 32'h0, 32'h0, 4'h0, rd, err, lat, ok);
        n_checks++;
        if ({ok, err, rd} !== {1'b1, 1'b0, 32'hCAFEF00D}) $display("FAIL word0_intact: got ok=%0d err=%b rdata=%h expected cafef00d", ok, err, rd);
        else n_pass++;
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd;
        logic        err;
        int          lat;
        bit          ok;
        int          seen;
        do_req(1'b1, 32'h20, 32'h0, 4'hF, rd, err, lat, ok);
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'h12345678;
        req_wstrb = 4'hF;
        @(negedge clk);
        req_valid = 1'b0;
        n_checks++;
        if (req_ready !== 1'b0) $display("FAIL abort_busy: got ready=%b after accept expected 0", req_ready);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        rst  = 1'b1;
        seen = (resp_valid === 1'b1) ? 1 : 0;
        n_checks++;
        if (req_ready !== 1'b1) $display("FAIL abort_idle: got ready=%b after reset expected 1", req_ready);
        else n_pass++;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid === 1'b1) seen++;
        end
        n_checks++;
        if (seen !== 0) $display("FAIL abort_noresp: got %0d responses expected 0", seen);
        else n_pass++;
        do_req(1'b0, 32'h20, 32'h0, 4'h0, rd, err, lat, ok);
        n_checks++;
        if ({ok, err, rd} !== {1'b1, 1'b0, 32'h0}) $display("FAIL abort_nowrite: got ok=%0d err=%b rdata=%h expected 00000000", ok, err, rd);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [6];
        logic [31:0] exps  [6];
        int          n_acc;
        int          n_resp;
        int          last_acc;
        int          cyc;
        int          extra;
        bit          sw;
        addrs = '{32'h10, 32'h20, 32'h10, 32'h20, 32'h0, 32'hFFC};
        exps  = '{32'h11AD33AA, 32'h0, 32'h11AD33AA, 32'h0, 32'hCAFEF00D, 32'h0BADC0DE};
        n_acc    = 0;
        n_resp   = 0;
        last_acc = -1;
        cyc      = 0;
        sw       = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = addrs[0];
        req_wdata = 32'hFFFFFFFF;
        req_wstrb = 4'hF;
        while (n_resp < 6 && cyc < 80) begin
            if (sw) begin
                sw = 1'b0;
                if (n_acc < 6) req_addr = addrs[n_acc];
                else req_valid = 1'b0;
            end
            if (resp_valid === 1'b1) begin
                if (n_resp < 6) begin
                    n_checks++;
                    if ({resp_err, resp_rdata} !== {1'b0, exps[n_resp]})
                        $display("FAIL b2b_data%0d: got err=%b rdata=%h expected err=0 rdata=%h", n_resp, resp_err, resp_rdata, exps[n_resp]);
                    else n_pass++;
                end
                n_resp++;
            end
            if (req_valid === 1'b1 && req_ready === 1'b1) begin
                if (last_acc >= 0) begin
                    n_checks++;
                    if (cyc - last_acc !== 3)
                        $display("FAIL b2b_spacing%0d: got %0d cycles expected 3", n_acc, cyc - last_acc);
                    else n_pass++;
                end
                last_acc = cyc;
                n_acc++;
                sw = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        req_valid = 1'b0;
        extra = 0;
        repeat (5) begin
            @(negedge clk);
            if (resp_valid === 1'b1) extra++;
        end
        n_checks++;
        if (n_acc !== 6) $display("FAIL b2b_accepts: got %0d expected 6", n_acc);
        else n_pass++;
        n_checks++;
        if (n_resp + extra !== 6) $display("FAIL b2b_responses: got %0d expected 6", n_resp + extra);
        else n_pass++;
    endtask

    // Scenario sequence
    initial begin
        test_reset();
        test_write_read();
        test_partial_write();
        test_errors();
        test_reset_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
